// File: rtl/pixel_gen_regions.sv
// pixel_gen_regions: striped VGA background with click-toggled stripe colours and cursor overlay.
// Latency: colour outputs are registered, one cycle after the h_cnt/v_cnt/valid sample.
// Backpressure: none; a pixel is produced every clock, and clicks are queued until vertical blanking.
module pixel_gen_regions #(
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter int          NUM_REGIONS = 4,
    parameter logic [11:0] COLOR_A     = 12'h0dd,
    parameter logic [11:0] COLOR_B     = 12'hb5f
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [9:0]             h_cnt,
    input  logic [9:0]             v_cnt,
    input  logic                   valid,
    input  logic                   enable_mouse_display,
    input  logic [11:0]            mouse_pixel,
    input  logic [9:0]             MOUSE_X_POS,
    input  logic                   MOUSE_LEFT,
    input  logic                   MOUSE_RIGHT,
    output logic [3:0]             vgaRed,
    output logic [3:0]             vgaGreen,
    output logic [3:0]             vgaBlue,
    output logic [NUM_REGIONS-1:0] region_state
);

    localparam int         REGION_W = H_ACTIVE / NUM_REGIONS;
    localparam logic [9:0] H_LIM    = 10'(H_ACTIVE);
    localparam logic [9:0] V_APPLY  = 10'(V_ACTIVE);

    // Stripe index by comparing against each stripe boundary; avoids a divider.
    // Coordinates past the active width saturate to the last stripe.
    function automatic int region_of(input logic [9:0] x);
        int idx;
        idx = 0;
        for (int k = 1; k < NUM_REGIONS; k++) begin
            if (int'(x) >= k * REGION_W) idx = k;
        end
        return idx;
    endfunction

    logic                   r_left_hist;
    logic                   r_right_hist;
    logic [NUM_REGIONS-1:0] r_pending;
    logic [NUM_REGIONS-1:0] r_region_state;
    logic [11:0]            r_color;

    logic                   w_left_rise;
    logic                   w_right_rise;
    logic                   w_apply;
    logic [NUM_REGIONS-1:0] w_toggle;
    int                     w_mouse_region;
    int                     w_pix_region;
    logic [11:0]            w_base;
    logic [11:0]            w_other;
    logic [11:0]            w_color;

    assign w_left_rise  = MOUSE_LEFT  & ~r_left_hist;
    assign w_right_rise = MOUSE_RIGHT & ~r_right_hist;
    assign w_apply      = (v_cnt == V_APPLY) && (h_cnt == 10'd0);

    // Build this cycle's toggle mask; right click flips everything and overrides a simultaneous left.
    always_comb begin
        w_toggle       = '0;
        w_mouse_region = region_of(MOUSE_X_POS);
        if (w_right_rise) begin
            w_toggle = '1;
        end else if (w_left_rise && (MOUSE_X_POS < H_LIM)) begin
            for (int k = 0; k < NUM_REGIONS; k++) begin
                w_toggle[k] = (w_mouse_region == k);
            end
        end
    end

    // Pick the next pixel colour: blanking black, then cursor, then (possibly flipped) stripe colour.
    always_comb begin
        w_pix_region = region_of(h_cnt);
        w_base       = (w_pix_region % 2 == 1) ? COLOR_B : COLOR_A;
        w_other      = (w_pix_region % 2 == 1) ? COLOR_A : COLOR_B;
        w_color      = 12'h000;
        if (valid && (h_cnt < H_LIM)) begin
            if (enable_mouse_display) begin
                w_color = mouse_pixel;
            end else if (r_region_state[w_pix_region]) begin
                w_color = w_other;
            end else begin
                w_color = w_base;
            end
        end
    end

    // Button history for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_left_hist  <= 1'b0;
            r_right_hist <= 1'b0;
        end else begin
            r_left_hist  <= MOUSE_LEFT;
            r_right_hist <= MOUSE_RIGHT;
        end
    end

    // Accumulate toggles during the frame and fold them into the display mask only at the apply
    // point; a click on the apply cycle itself becomes the first entry of the next frame's batch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending      <= '0;
            r_region_state <= '0;
        end else if (w_apply) begin
            r_region_state <= r_region_state ^ r_pending;
            r_pending      <= w_toggle;
        end else begin
            r_pending      <= r_pending ^ w_toggle;
        end
    end

    // Register the colour so the pins see a clean one-cycle-delayed pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_color <= 12'h000;
        end else begin
            r_color <= w_color;
        end
    end

    assign vgaRed       = r_color[11:8];
    assign vgaGreen     = r_color[7:4];
    assign vgaBlue      = r_color[3:0];
    assign region_state = r_region_state;

endmodule

// File: tb/tb_pixel_gen_regions.sv
// Testbench for pixel_gen_regions: directed scenarios plus randomized traffic checked against
// a click-list reference model (clicks collected per frame, replayed onto the stripes at blanking).
module tb_pixel_gen_regions;

    localparam int          HA = 640;
    localparam int          VA = 480;
    localparam int          NR = 4;
    localparam int          RW = HA / NR;
    localparam logic [11:0] CA = 12'h0dd;
    localparam logic [11:0] CB = 12'hb5f;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic          valid;
    logic          enable_mouse_display;
    logic [11:0]   mouse_pixel;
    logic [9:0]    MOUSE_X_POS;
    logic          MOUSE_LEFT;
    logic          MOUSE_RIGHT;
    logic [3:0]    vgaRed;
    logic [3:0]    vgaGreen;
    logic [3:0]    vgaBlue;
    logic [NR-1:0] region_state;

    always #5 clk = ~clk;

    pixel_gen_regions #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .NUM_REGIONS(NR), .COLOR_A(CA), .COLOR_B(CB)
    ) dut (
        .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
        .enable_mouse_display(enable_mouse_display), .mouse_pixel(mouse_pixel),
        .MOUSE_X_POS(MOUSE_X_POS), .MOUSE_LEFT(MOUSE_LEFT), .MOUSE_RIGHT(MOUSE_RIGHT),
        .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue), .region_state(region_state)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: displayed flips per stripe, and the list of clicks seen this frame
    // (stripe number, or -1 for a right click that hits every stripe).
    bit m_flip[NR];
    int m_clicks[$];
    bit m_prev_l;
    bit m_prev_r;

    function automatic logic [11:0] ref_colour();
        int r;
        logic [11:0] base;
        logic [11:0] other;
        if (!valid || int'(h_cnt) >= HA) return 12'h000;
        if (enable_mouse_display) return mouse_pixel;
        r     = int'(h_cnt) / RW;
        base  = (r % 2 == 0) ? CA : CB;
        other = (r % 2 == 0) ? CB : CA;
        return m_flip[r] ? other : base;
    endfunction

    function automatic logic [NR-1:0] ref_state();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = m_flip[i];
        return v;
    endfunction

    function automatic logic [11:0] dut_colour();
        return {vgaRed, vgaGreen, vgaBlue};
    endfunction

    // One clock: predict from current inputs, clock the DUT, compare just after the edge.
    task automatic step();
        logic [11:0] exp_col;
        bit          apply;
        bit          have_click;
        int          click;
        exp_col    = ref_colour();
        apply      = (int'(v_cnt) == VA) && (h_cnt == 10'd0);
        have_click = 1'b0;
        click      = 0;
        if (MOUSE_RIGHT && !m_prev_r) begin
            have_click = 1'b1;
            click      = -1;
        end else if (MOUSE_LEFT && !m_prev_l && int'(MOUSE_X_POS) < HA) begin
            have_click = 1'b1;
            click      = int'(MOUSE_X_POS) / RW;
        end
        if (apply) begin
            foreach (m_clicks[j]) begin
                for (int i = 0; i < NR; i++)
                    if (m_clicks[j] == -1 || m_clicks[j] == i) m_flip[i] = ~m_flip[i];
            end
            m_clicks.delete();
        end
        if (have_click) m_clicks.push_back(click);
        m_prev_l = MOUSE_LEFT;
        m_prev_r = MOUSE_RIGHT;
        @(posedge clk);
        #1;
        check("colour", 32'(dut_colour()), 32'(exp_col));
        check("region_state", 32'(region_state), 32'(ref_state()));
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) m_flip[i] = 1'b0;
        m_clicks.delete();
        m_prev_l = 1'b0;
        m_prev_r = 1'b0;
    endtask

    // Asynchronous reset taken mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset();
        rst         = 1'b1;
        MOUSE_LEFT  = 1'b0;
        MOUSE_RIGHT = 1'b0;
        #1;
        check("rst_colour", 32'(dut_colour()), 32'h0);
        check("rst_region_state", 32'(region_state), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic pix(input int h, input int v, input bit vl);
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        valid = vl;
        step();
    endtask

    task automatic pix_const(input string tag, input int h, input logic [11:0] exp);
        pix(h, 10, 1'b1);
        check(tag, 32'(dut_colour()), 32'(exp));
    endtask

    task automatic apply_cycle();
        pix(0, VA, 1'b0);
    endtask

    task automatic click_left(input int x);
        MOUSE_X_POS = 10'(x);
        MOUSE_LEFT  = 1'b1;
        pix(5, 100, 1'b1);
        pix(6, 100, 1'b1);   // held: no second toggle
        MOUSE_LEFT  = 1'b0;
        pix(7, 100, 1'b1);
    endtask

    initial begin
        rst                  = 1'b1;
        h_cnt                = '0;
        v_cnt                = '0;
        valid                = 1'b0;
        enable_mouse_display = 1'b0;
        mouse_pixel          = '0;
        MOUSE_X_POS          = '0;
        MOUSE_LEFT           = 1'b0;
        MOUSE_RIGHT          = 1'b0;
        model_clear();
        #2;
        check("reset_colour", 32'(dut_colour()), 32'h0);
        check("reset_region_state", 32'(region_state), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full line scan plus fixed stripe colours at the boundaries.
        for (int h = 0; h < 800; h++) pix(h, 10, h < HA);
        pix_const("stripe0_lo", 0,   CA);
        pix_const("stripe0_hi", 159, CA);
        pix_const("stripe1_lo", 160, CB);
        pix_const("stripe1_hi", 319, CB);
        pix_const("stripe2_lo", 320, CA);
        pix_const("stripe2_hi", 479, CA);
        pix_const("stripe3_lo", 480, CB);
        pix_const("stripe3_hi", 639, CB);
        pix_const("hblank",     700, 12'h000);

        // Single left click takes effect only at the apply point.
        click_left(200);
        pix_const("pre_apply_s1", 200, CB);
        check("pre_apply_state", 32'(region_state), 32'h0);
        apply_cycle();
        check("click200_state", 32'(region_state), 32'b0010);
        pix_const("post_apply_s1", 200, CA);

        // Double click cancels, out-of-range click ignored.
        do_reset();
        click_left(10);
        click_left(10);
        click_left(630);
        click_left(700);
        apply_cycle();
        check("cancel_state", 32'(region_state), 32'b1000);

        // Right wins over simultaneous left; second right restores.
        do_reset();
        MOUSE_X_POS = 10'd50;
        MOUSE_LEFT  = 1'b1;
        MOUSE_RIGHT = 1'b1;
        pix(5, 100, 1'b1);
        MOUSE_LEFT  = 1'b0;
        MOUSE_RIGHT = 1'b0;
        pix(6, 100, 1'b1);
        apply_cycle();
        check("right_all_state", 32'(region_state), 32'b1111);
        MOUSE_RIGHT = 1'b1;
        pix(5, 100, 1'b1);
        MOUSE_RIGHT = 1'b0;
        pix(6, 100, 1'b1);
        apply_cycle();
        check("right_back_state", 32'(region_state), 32'b0000);

        // Click on the apply cycle is deferred one frame.
        do_reset();
        MOUSE_X_POS = 10'd330;
        MOUSE_LEFT  = 1'b1;
        apply_cycle();
        check("apply_click_now", 32'(region_state), 32'b0000);
        MOUSE_LEFT  = 1'b0;
        pix(5, 100, 1'b1);
        apply_cycle();
        check("apply_click_next", 32'(region_state), 32'b0100);

        // Cursor priority and blanking.
        enable_mouse_display = 1'b1;
        mouse_pixel          = 12'hfff;
        pix(100, 50, 1'b1);
        check("cursor_valid", 32'(dut_colour()), 32'hfff);
        pix(100, 50, 1'b0);
        check("cursor_blank", 32'(dut_colour()), 32'h000);
        enable_mouse_display = 1'b0;

        // Randomized traffic with frequent apply points.
        for (int n = 0; n < 3000; n++) begin
            h_cnt                = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(0, 799));
            v_cnt                = 10'($urandom_range(475, 485));
            valid                = ($urandom_range(0, 3) != 0);
            enable_mouse_display = ($urandom_range(0, 7) == 0);
            mouse_pixel          = 12'($urandom());
            MOUSE_X_POS          = 10'($urandom_range(0, 799));
            if ($urandom_range(0, 9) == 0) MOUSE_LEFT  = ~MOUSE_LEFT;
            if ($urandom_range(0, 29) == 0) MOUSE_RIGHT = ~MOUSE_RIGHT;
            step();
        end

        // Reset in the middle of a line discards everything.
        pix(300, 200, 1'b1);
        do_reset();
        pix(200, 10, 1'b1);
        check("post_reset_s1", 32'(dut_colour()), 32'(CB));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pixel_gen_regions.md
Name: pixel_gen_regions

Overview:
Parametrised VGA background and cursor pixel generator. It splits the active width into NUM_REGIONS equal vertical stripes. Each stripe alternates between two colours, and mouse clicks toggle stripe colours. Toggles are frame-synchronised (applied only in vertical blanking) so the picture never tears. It sits between the VGA timing counters / mouse overlay and the VGA pins, with a registered one-cycle colour output.

Parameters:
H_ACTIVE, 640, active pixels per line; must be divisible by NUM_REGIONS.
V_ACTIVE, 480, active lines; the apply point is line V_ACTIVE.
NUM_REGIONS, 4, number of vertical stripes; range 1..16.
COLOR_A, 12'h0dd, base colour of even-indexed stripes.
COLOR_B, 12'hb5f, base colour of odd-indexed stripes.

Ports:
clk  input  1  pixel clock
rst  input  1  asynchronous reset, active-high
h_cnt  input  10  horizontal pixel counter
v_cnt  input  10  vertical line counter
valid  input  1  active-video qualifier
enable_mouse_display  input  1  cursor pixel present at (h_cnt, v_cnt)
mouse_pixel  input  12  cursor colour {R,G,B}
MOUSE_X_POS  input  10  cursor x position
MOUSE_LEFT  input  1  left button level
MOUSE_RIGHT  input  1  right button level
vgaRed  output  4  red, registered
vgaGreen  output  4  green, registered
vgaBlue  output  4  blue, registered
region_state  output  NUM_REGIONS  currently displayed flip mask (bit i = stripe i flipped)

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset state: vgaRed, vgaGreen and vgaBlue all 0. region_state is 0, the pending mask is 0, and both button-history flops are 0.
- Region width: REGION_W = H_ACTIVE/NUM_REGIONS.
  - Region index of a coordinate x is floor(x/REGION_W).
  - Implement with a comparator chain or priority search; no divider.
- Button edge detection: registered history of MOUSE_LEFT and MOUSE_RIGHT. A rise is level=1 with history=0, detected in the cycle the level first reads 1.
- Toggle generation (per cycle):
  - Right rise: toggle mask = all ones.
  - Left rise with MOUSE_X_POS < H_ACTIVE: toggle mask = one-hot of region(MOUSE_X_POS).
  - Left rise with MOUSE_X_POS >= H_ACTIVE: toggle mask = 0 (ignored).
  - Right and left rise in the same cycle: right wins, left discarded.
  - Held buttons produce no further toggles.
- Apply point: the cycle with v_cnt == V_ACTIVE && h_cnt == 0.
- Pending mask:
  - Outside the apply point: pending <= pending ^ toggle.
  - At the apply point: region_state <= region_state ^ pending, and pending <= toggle. A click landing on the apply cycle therefore takes effect next frame and is not lost.
  - Two clicks on the same region within one frame cancel (net no change).
- region_state changes only at the apply point, never during active video.
- Colour select, registered with 1-cycle latency (outputs at edge N+1 reflect inputs sampled at edge N):
  - valid == 0 -> 12'h000.
  - valid and h_cnt >= H_ACTIVE -> 12'h000 (defensive).
  - valid and enable_mouse_display -> mouse_pixel (cursor has priority over background).
  - Otherwise, with i = region(h_cnt) and base = (i even) ? COLOR_A : COLOR_B: output base if region_state[i] == 0, else the other colour.
  - Colour mapping: {vgaRed, vgaGreen, vgaBlue} = 12-bit value.
- Stripe alignment: the one-cycle output delay is matched by the timing block delaying hsync/vsync by one cycle; this block does not delay sync.
- NUM_REGIONS == 1: every left click toggles stripe 0; right click also toggles it.
- Reset mid-frame: pending clicks are discarded, all stripes return to base colours, and outputs are 0 starting the cycle rst asserts.

Test Plan:
- Reset, then scan a full frame with no clicks, NUM_REGIONS=4 -> h_cnt 0..159 gives 12'h0dd, 160..319 gives 12'hb5f, 320..479 gives 12'h0dd, 480..639 gives 12'hb5f (all one cycle late); blanking gives 12'h000.
- Left rise with MOUSE_X_POS=200 on line 100 -> current frame unchanged; after the apply cycle (v_cnt=480, h_cnt=0) region_state=4'b0010 and h_cnt 160..319 shows 12'h0dd.
- Two left rises at MOUSE_X_POS=10 in one frame, plus one at 630 -> after apply region_state=4'b1000 (double click cancels); a left rise at MOUSE_X_POS=700 produces no change.
- Right and left rise in the same cycle at MOUSE_X_POS=50, then apply -> region_state=4'b1111; a second right rise the next frame returns it to 4'b0000.
- Left rise exactly on the apply cycle at MOUSE_X_POS=330 -> region_state unchanged at that apply; becomes 4'b0100 at the following frame's apply.
- With enable_mouse_display=1 and mouse_pixel=12'hfff at a valid pixel -> output 12'hfff next cycle. With valid=0 and enable_mouse_display=1 -> output 12'h000. Asserting rst mid-line -> outputs 0 immediately and region_state=0.
